// File: rtl/fir_tap_booth_mult.sv
// ----------------------------------------------------------------------------
// fir_tap_booth_mult
//
// Sequential radix-2 Booth signed multiplier for one FIR tap product
// (sample x coefficient). One Booth step per clock. The result is presented
// with a one-cycle load strobe for the downstream tap product delay register.
//
// Ports:
//   clk           clock, rising edge
//   rst           asynchronous, active-high reset
//   start         request a multiply; sampled only while idle
//   sample_in     signed sample operand, captured on accept
//   coeff_in      signed coefficient operand, captured on accept
//   busy          high while a multiply is running or completing
//   done          one-cycle pulse, product_out newly valid
//   ld_delay_out  delay-register load strobe, same timing as done
//   product_out   signed full-precision product, held until next completion
// ----------------------------------------------------------------------------
module fir_tap_booth_mult #(
    parameter int DATAWIDTH     = 16,
    parameter int PRODUCT_WIDTH = 2 * DATAWIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [DATAWIDTH-1:0]     sample_in,
    input  logic [DATAWIDTH-1:0]     coeff_in,
    output logic                     busy,
    output logic                     done,
    output logic                     ld_delay_out,
    output logic [PRODUCT_WIDTH-1:0] product_out
);

    localparam int CW = $clog2(DATAWIDTH);
    localparam logic [CW-1:0] LastStep = CW'(DATAWIDTH - 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [DATAWIDTH-1:0]       r_mcand;
    logic [DATAWIDTH:0]         r_acc;    // one guard bit: A +/- M never overflows
    logic [DATAWIDTH-1:0]       r_q;
    logic                       r_qm1;
    logic [CW-1:0]              r_cnt;
    logic [PRODUCT_WIDTH-1:0]   r_product;
    logic                       r_done;

    logic [DATAWIDTH:0]         w_m_ext;
    logic [DATAWIDTH:0]         w_sum;
    logic [DATAWIDTH:0]         w_acc_sh;
    logic [DATAWIDTH-1:0]       w_q_sh;
    logic                       w_last;

    // Booth step: add/subtract by {Q[0], q_-1}, then arithmetic shift of {A,Q,q_-1}.
    always_comb begin
        w_m_ext = {r_mcand[DATAWIDTH-1], r_mcand};
        case ({r_q[0], r_qm1})
            2'b01:   w_sum = r_acc + w_m_ext;
            2'b10:   w_sum = r_acc - w_m_ext;
            default: w_sum = r_acc;
        endcase
        w_acc_sh = {w_sum[DATAWIDTH], w_sum[DATAWIDTH:1]};
        w_q_sh   = {w_sum[0], r_q[DATAWIDTH-1:1]};
        w_last   = (r_cnt == LastStep);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle:  if (start) w_state_nxt = StRun;
            StRun:   if (w_last) w_state_nxt = StDone;
            StDone:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcand   <= '0;
            r_acc     <= '0;
            r_q       <= '0;
            r_qm1     <= 1'b0;
            r_cnt     <= '0;
            r_product <= '0;
            r_done    <= 1'b0;
        end else begin
            // done is registered from the next-state decode so it is glitch-free
            // and coincides exactly with the DONE state.
            r_done <= (w_state_nxt == StDone);
            case (r_state)
                StIdle: begin
                    if (start) begin
                        r_mcand <= coeff_in;
                        r_acc   <= '0;
                        r_q     <= sample_in;
                        r_qm1   <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
                StRun: begin
                    r_acc <= w_acc_sh;
                    r_q   <= w_q_sh;
                    r_qm1 <= r_q[0];
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_product <= {w_acc_sh[DATAWIDTH-1:0], w_q_sh};
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy         = (r_state != StIdle);
    assign done         = r_done;
    assign ld_delay_out = r_done;
    assign product_out  = r_product;

endmodule

// File: tb/tb_fir_tap_booth_mult.sv
module tb_fir_tap_booth_mult;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] sample_in;
    logic [15:0] coeff_in;
    logic        busy;
    logic        done;
    logic        ld_delay_out;
    logic [31:0] product_out;

    int n_vec = 0;
    int n_err = 0;

    fir_tap_booth_mult #(
        .DATAWIDTH    (16),
        .PRODUCT_WIDTH(32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .sample_in   (sample_in),
        .coeff_in    (coeff_in),
        .busy        (busy),
        .done        (done),
        .ld_delay_out(ld_delay_out),
        .product_out (product_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one multiply, wait (bounded) for done. Returns edges from accept
    // to done, number of sampled cycles busy was high, and the product.
    task automatic run_mult(input logic [15:0] s, input logic [15:0] c,
                            output logic [31:0] p, output int lat, output int bcnt);
        sample_in = s;
        coeff_in  = c;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        sample_in = 16'hDEAD;
        coeff_in  = 16'hBEEF;
        lat  = 0;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (busy) bcnt++;
        end
        p = product_out;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        sample_in = '0;
        coeff_in = '0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({busy, done, ld_delay_out, product_out} !== 35'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got busy=%b done=%b ld=%b prod=%h, want all 0",
                     busy, done, ld_delay_out, product_out);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [31:0] p;
        int lat, bcnt;
        run_mult(16'd3, 16'd5, p, lat, bcnt);
        n_vec++;
        if (lat !== 16) begin
            n_err++;
            $display("FAIL basic_latency: got %0d edges, want 16", lat);
        end
        n_vec++;
        if (p !== 32'd15) begin
            n_err++;
            $display("FAIL basic_product: got %h, want 0000000f", p);
        end
        n_vec++;
        if (ld_delay_out !== 1'b1) begin
            n_err++;
            $display("FAIL basic_ld_with_done: got ld=%b, want 1", ld_delay_out);
        end
        @(posedge clk); #1;
        n_vec++;
        if ({done, ld_delay_out, busy} !== 3'b000) begin
            n_err++;
            $display("FAIL basic_single_pulse: got done=%b ld=%b busy=%b, want 000",
                     done, ld_delay_out, busy);
        end
        n_vec++;
        if (bcnt !== 17) begin
            n_err++;
            $display("FAIL basic_busy_cycles: got %0d, want 17", bcnt);
        end
    endtask

    task automatic test_corners();
        logic [15:0] s_tab [5] = '{16'h8000, 16'hFFFF, 16'h7FFF, 16'h0000, 16'hFFFB};
        logic [15:0] c_tab [5] = '{16'h8000, 16'h7FFF, 16'h7FFF, 16'hFFFB, 16'h0000};
        logic [31:0] e_tab [5] = '{32'h4000_0000, 32'hFFFF_8001, 32'h3FFF_0001,
                                   32'h0000_0000, 32'h0000_0000};
        logic [31:0] p;
        int lat, bcnt;
        for (int i = 0; i < 5; i++) begin
            run_mult(s_tab[i], c_tab[i], p, lat, bcnt);
            n_vec++;
            if (lat !== 16 || p !== e_tab[i]) begin
                n_err++;
                $display("FAIL corner_%0d: got %h after %0d edges, want %h after 16",
                         i, p, lat, e_tab[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_ignore_start();
        int lat, bcnt;
        logic held_ok;
        logic [31:0] prev;
        prev      = product_out;
        held_ok   = 1'b1;
        sample_in = 16'd11;
        coeff_in  = 16'hFFF3;  // -13
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 0;
        bcnt  = busy ? 1 : 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (busy) bcnt++;
            if (!done && product_out !== prev) held_ok = 1'b0;
            if (lat == 3) begin
                start     = 1'b1;
                sample_in = 16'd100;
                coeff_in  = 16'd100;
            end else if (lat == 4) begin
                start = 1'b0;
            end
        end
        n_vec++;
        if (product_out !== 32'hFFFF_FF71 || lat !== 16) begin
            n_err++;
            $display("FAIL ignore_product: got %h after %0d edges, want ffffff71 after 16",
                     product_out, lat);
        end
        n_vec++;
        if (!held_ok) begin
            n_err++;
            $display("FAIL ignore_hold: product changed mid-run, want held at %h", prev);
        end
        @(posedge clk); #1;
        n_vec++;
        if (bcnt !== 17 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL ignore_busy: got %0d busy cycles, busy now %b, want 17 and 0",
                     bcnt, busy);
        end
    endtask

    task automatic test_reset_midop();
        logic [31:0] p;
        int lat, bcnt;
        logic saw_done;
        saw_done  = 1'b0;
        sample_in = 16'd6;
        coeff_in  = 16'd7;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({busy, done, ld_delay_out, product_out} !== 35'd0) begin
            n_err++;
            $display("FAIL midop_reset_async: got busy=%b done=%b ld=%b prod=%h, want all 0",
                     busy, done, ld_delay_out, product_out);
        end
        repeat (3) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        rst = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        n_vec++;
        if (saw_done !== 1'b0) begin
            n_err++;
            $display("FAIL midop_no_done: got a done pulse, want none");
        end
        run_mult(16'hFFF9, 16'd9, p, lat, bcnt);
        n_vec++;
        if (p !== 32'hFFFF_FFC1 || lat !== 16) begin
            n_err++;
            $display("FAIL midop_after_reset: got %h after %0d edges, want ffffffc1 after 16",
                     p, lat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_p [3] = '{32'hFFFF_FFFA, 32'h0000_2710, 32'h0000_0001};
        int   edge_at [3];
        logic [31:0] got_p [3];
        int   nd, cyc;
        logic stable_ok, prev_done;
        logic [31:0] last_p;
        nd = 0; cyc = 0; stable_ok = 1'b1; prev_done = 1'b0;
        sample_in = 16'd2;
        coeff_in  = 16'hFFFD;
        start     = 1'b1;
        @(posedge clk); #1;
        last_p    = product_out;
        sample_in = 16'd100;
        coeff_in  = 16'd100;
        while (nd < 3 && cyc < 80) begin
            @(posedge clk); #1;
            cyc++;
            if (done) begin
                if (prev_done) stable_ok = 1'b0;
                edge_at[nd] = cyc;
                got_p[nd]   = product_out;
                last_p      = product_out;
                nd++;
                if (nd == 2) begin
                    sample_in = 16'hFFFF;
                    coeff_in  = 16'hFFFF;
                end
            end else if (product_out !== last_p) begin
                stable_ok = 1'b0;
            end
            prev_done = done;
        end
        start = 1'b0;
        n_vec++;
        if (nd !== 3) begin
            n_err++;
            $display("FAIL b2b_count: got %0d done pulses, want 3", nd);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_vec++;
                if (got_p[i] !== exp_p[i] || edge_at[i] !== 16 + 18 * i) begin
                    n_err++;
                    $display("FAIL b2b_op%0d: got %h at edge %0d, want %h at edge %0d",
                             i, got_p[i], edge_at[i], exp_p[i], 16 + 18 * i);
                end
            end
        end
        n_vec++;
        if (!stable_ok) begin
            n_err++;
            $display("FAIL b2b_stable: product changed between pulses or done doubled");
        end
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_idle: got busy=%b after start dropped, want 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_ignore_start();
        test_reset_midop();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fir_tap_booth_mult.md
Name: fir_tap_booth_mult

Overview:
Sequential radix-2 Booth signed multiplier forming one FIR tap product (sample × coefficient). It sits directly upstream of the tap product delay register. It drives the full-precision product together with a one-cycle load strobe that the delay register consumes as its load enable. It replaces a combinational multiplier so the tap datapath is area-lean, with a start/busy/done handshake toward the FIR controller.

Parameters:
DATAWIDTH, 16, width of signed sample and coefficient operands (≥2)
PRODUCT_WIDTH, 2*DATAWIDTH, width of signed product output; must equal 2*DATAWIDTH

Ports:
clk  input  1  clock, all state changes on rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  request a multiply; sampled only in IDLE
sample_in  input  DATAWIDTH  signed sample operand, captured on accept
coeff_in  input  DATAWIDTH  signed coefficient operand, captured on accept
busy  output  1  high while in RUN or DONE
done  output  1  one-cycle pulse, product_out newly valid
ld_delay_out  output  1  load strobe for downstream delay register; identical timing to done
product_out  output  PRODUCT_WIDTH  signed product, held until next completion

Behaviour:
- Clock clk; reset rst, asynchronous, active-high.
- Reset values: state=IDLE; busy=0, done=0, ld_delay_out=0, product_out=0; all internal registers (multiplicand, accumulator, step counter) = 0.
- States:
  - IDLE:
    - start=1: capture coeff_in as multiplicand M.
    - Init Booth register {A=0, Q=sample_in, q_-1=0}, counter=0, go RUN.
    - start=0: stay.
  - RUN:
    - One Booth step per cycle. Inspect {Q[0], q_-1}: 01 → A=A+M, 10 → A=A−M, 00/11 → no add.
    - Then arithmetic right shift of {A,Q,q_-1}. counter++.
    - A is DATAWIDTH+1 bits (sign-extended M) so no intermediate overflow.
    - On the step where counter==DATAWIDTH-1: load product_out with {A,Q} low PRODUCT_WIDTH bits after that shift, go DONE.
  - DONE: done=1, ld_delay_out=1 for exactly this cycle; go IDLE unconditionally.
- Latency: start sampled at edge E0 → DATAWIDTH Booth steps at E1..E_DATAWIDTH.
  - product_out updates and done rises at E_DATAWIDTH.
  - IDLE re-entered at E_DATAWIDTH+1.
  - Minimum start-to-start spacing is DATAWIDTH+2 cycles.
- start while busy=1 is ignored (not queued). Operand inputs are don't-care after the accept edge.
- Arithmetic: exact two's-complement product, no rounding, no saturation. Full range is representable, including (−2^(DW−1))×(−2^(DW−1)) = 2^(2DW−2).
- product_out changes only at the DONE transition. It holds its value through IDLE and subsequent RUN phases.
- done/ld_delay_out are registered outputs (state decode registered), glitch-free, never high for two consecutive cycles.
- Reset mid-operation: immediate return to IDLE with reset values; the in-flight product is discarded and no done pulse is produced.
- start held continuously high: a new multiply is accepted on each IDLE cycle, giving back-to-back operations at DATAWIDTH+2 spacing.

Test Plan:
- Reset release, start=1, sample_in=3, coeff_in=5 → done pulse exactly 16 cycles after accept edge; product_out=15; ld_delay_out coincident with done, single cycle.
- sample_in=−32768, coeff_in=−32768 → product_out=0x40000000 (1073741824); sample=−1, coeff=32767 → 0xFFFF8001.
- sample=0x7FFF, coeff=0x7FFF → 0x3FFF0001. Either operand 0 → 0. Check no stale upper bits.
- start pulsed at accept+3 and operands changed mid-RUN → ignored; result reflects the originally captured operands; busy high 17 cycles (RUN+DONE).
- rst asserted asynchronously at accept+8 → outputs 0 immediately, no done; a new multiply after reset (−7×9) → −63.
- start held high for 3 operations with operand pairs (2,−3),(100,100),(−1,−1) → products −6, 10000, 1 at done edges spaced 18 cycles apart; product_out stable between pulses.
